// File: rtl/rv32_imm_pkg.sv
// Shared types and immediate decode function for the immediate stage.
// Provides fmt_e, opcode constants and imm_decode() returning {fmt, imm64}.
package rv32_imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_CI   = 3'd6,
        FMT_CBJ  = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        fmt_e        fmt;
        logic [63:0] imm;
    } dec_t;

    // Decodes at 64 bits; narrower datapaths keep the low XLEN bits,
    // which is identical to sign-extending directly at that width.
    // C.JAL shares its encoding with C.ADDIW on RV64, hence xlen64.
    function automatic dec_t imm_decode(input logic [31:0] i,
                                        input logic rvc_en,
                                        input logic xlen64);
        dec_t d;
        d.fmt = FMT_NONE;
        d.imm = '0;
        if (i[1:0] == 2'b11) begin
            unique case (i[6:0])
                OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_MISC: begin
                    d.fmt = FMT_I;
                    d.imm = {{52{i[31]}}, i[31:20]};
                end
                OP_STORE: begin
                    d.fmt = FMT_S;
                    d.imm = {{52{i[31]}}, i[31:25], i[11:7]};
                end
                OP_BRANCH: begin
                    d.fmt = FMT_B;
                    d.imm = {{52{i[31]}}, i[7], i[30:25],
                             i[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    d.fmt = FMT_U;
                    d.imm = {{32{i[31]}}, i[31:12], 12'b0};
                end
                OP_JAL: begin
                    d.fmt = FMT_J;
                    d.imm = {{44{i[31]}}, i[19:12], i[20],
                             i[30:21], 1'b0};
                end
                default: ;
            endcase
        end else if (rvc_en && i[1:0] == 2'b01) begin
            unique case (i[15:13])
                3'b000, 3'b010: begin
                    d.fmt = FMT_CI;
                    d.imm = {{59{i[12]}}, i[6:2]};
                end
                3'b101, 3'b001: begin
                    if (i[15] || !xlen64) begin
                        d.fmt = FMT_CBJ;
                        d.imm = {{53{i[12]}}, i[8], i[10:9], i[6],
                                 i[7], i[2], i[11], i[5:3], 1'b0};
                    end
                end
                3'b110, 3'b111: begin
                    d.fmt = FMT_CBJ;
                    d.imm = {{56{i[12]}}, i[6:5], i[2], i[11:10],
                             i[4:3], 1'b0};
                end
                default: ;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/rv32_imm_stage_if.sv
// Handshake bundle between fetch-side producer and decode-side consumer.
// master drives in_*/out_ready/flush; slave (the stage) drives the rest.
interface rv32_imm_stage_if
    import rv32_imm_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic            out_pcrel;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt,
        input  out_pcrel, out_target, out_pc, out_instr
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt,
        output out_pcrel, out_target, out_pc, out_instr
    );
endinterface

// File: rtl/rv32_imm_dec.sv
// Combinational immediate decode (32-bit and optional RVC quadrant 01).
// Ports: instr in; fmt, XLEN-bit sign-extended imm, pcrel out.
module rv32_imm_dec
    import rv32_imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RVC_EN = 0
) (
    input  logic [31:0]     instr,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic            pcrel
);
    dec_t d;
    logic unused_hi;

    always_comb d = imm_decode(instr, RVC_EN != 0, XLEN == 64);

    assign fmt   = d.fmt;
    assign imm   = d.imm[XLEN-1:0];
    assign pcrel = (d.fmt == FMT_B) || (d.fmt == FMT_J) ||
                   (d.fmt == FMT_CBJ);

    // Upper decode bits are dropped on a 32-bit datapath.
    assign unused_hi = ^d.imm;
endmodule

// File: rtl/rv32_imm_stage.sv
// Immediate stage: decode + PC-relative adder, output reg and skid entry.
// Ports: clk, rst (sync, active-high), bus (slave side of the handshake).
module rv32_imm_stage
    import rv32_imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RVC_EN = 0
) (
    input  logic clk,
    input  logic rst,
    rv32_imm_stage_if.slave bus
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("rv32_imm_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            pcrel;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } ent_t;

    fmt_e            dfmt;
    logic [XLEN-1:0] dimm;
    logic            dpcrel;
    ent_t            nxt;
    ent_t            outr;
    ent_t            skid;
    logic            out_v;
    logic            skid_v;
    logic            accept;
    logic            load_out;

    rv32_imm_dec #(
        .XLEN   (XLEN),
        .RVC_EN (RVC_EN)
    ) u_dec (
        .instr (bus.in_instr),
        .fmt   (dfmt),
        .imm   (dimm),
        .pcrel (dpcrel)
    );

    always_comb begin
        nxt.imm    = dimm;
        nxt.fmt    = dfmt;
        nxt.pcrel  = dpcrel;
        nxt.target = bus.in_pc + dimm;
        nxt.pc     = bus.in_pc;
        nxt.instr  = bus.in_instr;
    end

    assign bus.in_ready = !skid_v && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    // Output register may take new data when empty or being drained.
    assign load_out     = !out_v || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            outr   <= '0;
            skid   <= '0;
        end else if (bus.flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (load_out) begin
            // Skid entry is older than any new beat; in_ready is low
            // whenever it is full, so no accept competes with it.
            if (skid_v) begin
                outr   <= skid;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else if (accept) begin
                outr  <= nxt;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (accept) begin
            skid   <= nxt;
            skid_v <= 1'b1;
        end
    end

    assign bus.out_valid  = out_v;
    assign bus.out_imm    = outr.imm;
    assign bus.out_fmt    = outr.fmt;
    assign bus.out_pcrel  = outr.pcrel;
    assign bus.out_target = outr.target;
    assign bus.out_pc     = outr.pc;
    assign bus.out_instr  = outr.instr;
endmodule

// File: tb/tb_rv32_imm_stage.sv
// Directed bench for rv32_imm_stage: three configurations share stimulus.
// d0: XLEN32/RVC0, d1: XLEN32/RVC1, d2: XLEN64/RVC1.
module tb_rv32_imm_stage;
    import rv32_imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        out_ready;
    int          sel;
    int          ncmp = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    rv32_imm_stage_if #(.XLEN(32)) if0 ();
    rv32_imm_stage_if #(.XLEN(32)) if1 ();
    rv32_imm_stage_if #(.XLEN(64)) if2 ();

    assign if0.flush = flush;
    assign if0.in_valid = in_valid;
    assign if0.in_instr = instr;
    assign if0.in_pc = pc[31:0];
    assign if0.out_ready = out_ready;
    assign if1.flush = flush;
    assign if1.in_valid = in_valid;
    assign if1.in_instr = instr;
    assign if1.in_pc = pc[31:0];
    assign if1.out_ready = out_ready;
    assign if2.flush = flush;
    assign if2.in_valid = in_valid;
    assign if2.in_instr = instr;
    assign if2.in_pc = pc;
    assign if2.out_ready = out_ready;

    rv32_imm_stage #(.XLEN(32), .RVC_EN(0)) d0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    rv32_imm_stage #(.XLEN(32), .RVC_EN(1)) d1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    rv32_imm_stage #(.XLEN(64), .RVC_EN(1)) d2 (
        .clk(clk), .rst(rst), .bus(if2.slave));

    logic        a_ov;
    logic [63:0] a_imm;
    logic [2:0]  a_fmt;
    logic        a_pcrel;
    logic [63:0] a_tgt;
    logic [63:0] a_pc;
    logic [31:0] a_ins;

    always_comb begin
        a_ov = if0.out_valid;
        a_imm = {32'b0, if0.out_imm};
        a_fmt = if0.out_fmt;
        a_pcrel = if0.out_pcrel;
        a_tgt = {32'b0, if0.out_target};
        a_pc = {32'b0, if0.out_pc};
        a_ins = if0.out_instr;
        if (sel == 1) begin
            a_ov = if1.out_valid;
            a_imm = {32'b0, if1.out_imm};
            a_fmt = if1.out_fmt;
            a_pcrel = if1.out_pcrel;
            a_tgt = {32'b0, if1.out_target};
            a_pc = {32'b0, if1.out_pc};
            a_ins = if1.out_instr;
        end else if (sel == 2) begin
            a_ov = if2.out_valid;
            a_imm = if2.out_imm;
            a_fmt = if2.out_fmt;
            a_pcrel = if2.out_pcrel;
            a_tgt = if2.out_target;
            a_pc = if2.out_pc;
            a_ins = if2.out_instr;
        end
    end

    typedef struct {
        int          sel;
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        pcrel;
        logic [63:0] tgt;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{0, 32'hFFF00093, 64'h0, 3'd1,
                   64'hFFFFFFFF, 1'b0, 64'hFFFFFFFF};
        vt[1]  = '{0, 32'hFE000EE3, 64'h100, 3'd3,
                   64'hFFFFFFFC, 1'b1, 64'hFC};
        vt[2]  = '{0, 32'hFE112C23, 64'h10, 3'd2,
                   64'hFFFFFFF8, 1'b0, 64'h8};
        vt[3]  = '{0, 32'h12345097, 64'h1000, 3'd4,
                   64'h12345000, 1'b0, 64'h12346000};
        vt[4]  = '{0, 32'h0080006F, 64'h200, 3'd5,
                   64'h8, 1'b1, 64'h208};
        vt[5]  = '{0, 32'h010080E7, 64'h40, 3'd1,
                   64'h10, 1'b0, 64'h50};
        vt[6]  = '{0, 32'h002081B3, 64'h44, 3'd0,
                   64'h0, 1'b0, 64'h44};
        vt[7]  = '{0, 32'h000050FD, 64'h300, 3'd0,
                   64'h0, 1'b0, 64'h300};
        vt[8]  = '{1, 32'h000050FD, 64'h4, 3'd6,
                   64'hFFFFFFFF, 1'b0, 64'h3};
        vt[9]  = '{1, 32'h0000BFFD, 64'h100, 3'd7,
                   64'hFFFFFFFE, 1'b1, 64'hFE};
        vt[10] = '{1, 32'h00002801, 64'h20, 3'd7,
                   64'h10, 1'b1, 64'h30};
        vt[11] = '{1, 32'h0000C01D, 64'h100, 3'd7,
                   64'h26, 1'b1, 64'h126};
        vt[12] = '{1, 32'h0000F001, 64'h200, 3'd7,
                   64'hFFFFFF00, 1'b1, 64'h100};
        vt[13] = '{1, 32'h00008082, 64'h50, 3'd0,
                   64'h0, 1'b0, 64'h50};
        vt[14] = '{1, 32'hDEAD50FD, 64'h10, 3'd6,
                   64'hFFFFFFFF, 1'b0, 64'hF};
        vt[15] = '{2, 32'h800000B7, 64'h0, 3'd4,
                   64'hFFFFFFFF80000000, 1'b0, 64'hFFFFFFFF80000000};
        vt[16] = '{2, 32'h123450B7, 64'h1000, 3'd4,
                   64'h12345000, 1'b0, 64'h12346000};
        vt[17] = '{2, 32'h00002801, 64'h8, 3'd0,
                   64'h0, 1'b0, 64'h8};
        vt[18] = '{2, 32'hFE000EE3, 64'h100, 3'd3,
                   64'hFFFFFFFFFFFFFFFC, 1'b1, 64'hFC};
        vt[19] = '{2, 32'hFFF00093, 64'h100000000, 3'd1,
                   64'hFFFFFFFFFFFFFFFF, 1'b0, 64'hFFFFFFFF};
        vt[20] = '{0, 32'h0000BFFD, 64'h0, 3'd0,
                   64'h0, 1'b0, 64'h0};

        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        instr = '0;
        pc = '0;
        out_ready = 1'b0;
        sel = 0;
        repeat (3) tick();

        chk("rst ov0", 64'(if0.out_valid), 64'h0);
        chk("rst ir0", 64'(if0.in_ready), 64'h0);
        chk("rst imm0", 64'(if0.out_imm), 64'h0);
        chk("rst ins0", 64'(if0.out_instr), 64'h0);
        chk("rst ov2", 64'(if2.out_valid), 64'h0);
        chk("rst tgt2", if2.out_target, 64'h0);
        chk("rst pc2", if2.out_pc, 64'h0);

        rst = 1'b0;
        tick();
        chk("post-rst ir", 64'(if0.in_ready), 64'h1);

        out_ready = 1'b1;
        for (int k = 0; k < 21; k++) begin
            sel = vt[k].sel;
            instr = vt[k].instr;
            pc = vt[k].pc;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d ov", k), 64'(a_ov), 64'h1);
            chk($sformatf("v%0d fmt", k), 64'(a_fmt), 64'(vt[k].fmt));
            chk($sformatf("v%0d imm", k), a_imm, vt[k].imm);
            chk($sformatf("v%0d pcrel", k), 64'(a_pcrel),
                64'(vt[k].pcrel));
            chk($sformatf("v%0d tgt", k), a_tgt, vt[k].tgt);
            chk($sformatf("v%0d pc", k), a_pc, vt[k].pc);
            chk($sformatf("v%0d ins", k), 64'(a_ins), 64'(vt[k].instr));
        end
        tick();
        chk("drain ov", 64'(if0.out_valid), 64'h0);

        // Backpressure: A, B held; C refused until skid drains.
        out_ready = 1'b0;
        instr = 32'h00100093;
        pc = 64'h10;
        in_valid = 1'b1;
        tick();
        chk("bp ir1", 64'(if0.in_ready), 64'h1);
        chk("bp outA", 64'(if0.out_instr), 64'h00100093);
        instr = 32'h00200093;
        pc = 64'h14;
        tick();
        chk("bp ir2", 64'(if0.in_ready), 64'h0);
        chk("bp ov2", 64'(if0.out_valid), 64'h1);
        chk("bp keepA", 64'(if0.out_instr), 64'h00100093);
        instr = 32'h00300093;
        pc = 64'h18;
        tick();
        chk("bp ir3", 64'(if0.in_ready), 64'h0);
        chk("bp holdA", 64'(if0.out_instr), 64'h00100093);
        chk("bp holdimm", 64'(if0.out_imm), 64'h1);
        chk("bp holdpc", 64'(if0.out_pc), 64'h10);
        out_ready = 1'b1;
        tick();
        chk("bp outB", 64'(if0.out_instr), 64'h00200093);
        chk("bp immB", 64'(if0.out_imm), 64'h2);
        chk("bp ovB", 64'(if0.out_valid), 64'h1);
        chk("bp ir4", 64'(if0.in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        chk("bp outC", 64'(if0.out_instr), 64'h00300093);
        chk("bp immC", 64'(if0.out_imm), 64'h3);
        chk("bp pcC", 64'(if0.out_pc), 64'h18);
        chk("bp ovC", 64'(if0.out_valid), 64'h1);
        tick();
        chk("bp empty", 64'(if0.out_valid), 64'h0);

        // Flush with both entries full and a beat offered.
        out_ready = 1'b0;
        instr = 32'h00400093;
        in_valid = 1'b1;
        tick();
        instr = 32'h00500093;
        tick();
        chk("fl full", 64'(if0.in_ready), 64'h0);
        instr = 32'h00700093;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl ov", 64'(if0.out_valid), 64'h0);
        chk("fl ir", 64'(if0.in_ready), 64'h1);
        chk("fl ov64", 64'(if2.out_valid), 64'h0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("fl gone%0d", c), 64'(if0.out_valid), 64'h0);
        end

        // Reset mid-operation discards both entries.
        out_ready = 1'b0;
        instr = 32'h00600093;
        pc = 64'h20;
        in_valid = 1'b1;
        tick();
        instr = 32'h00800093;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mrst ov", 64'(if0.out_valid), 64'h0);
        chk("mrst ir", 64'(if0.in_ready), 64'h0);
        chk("mrst imm", 64'(if0.out_imm), 64'h0);
        chk("mrst ins", 64'(if0.out_instr), 64'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mrst ov2", 64'(if0.out_valid), 64'h0);
        chk("mrst ir2", 64'(if0.in_ready), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/rv32_imm_stage.md
# rv32_imm_stage

Pipelined, parametrised immediate-extraction stage for the decode path. It accepts one instruction word plus its PC per cycle over a valid/ready handshake. It returns four results through a registered, skid-buffered output:
- the sign-extended immediate,
- a format code,
- a PC-relative flag,
- the precomputed PC-relative target.

Compared with the purely combinational immediate generator, it adds XLEN=64, optional compressed (RVC) immediates, branch/jump target precompute, and full backpressure/flush support, so it can sit directly between fetch and decode.

## Interface
- `XLEN`, 32: datapath width; only 32 or 64 are legal (elaboration error otherwise).
- `RVC_EN`, 0: 1 enables decode of compressed immediates.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all held entries.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_instr`  in  32  instruction word; bits [31:16] are ignored for compressed words.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_imm`  out  XLEN  sign-extended immediate.
- `out_fmt`  out  3  format code (see Structure).
- `out_pcrel`  out  1  1 for B, J and compressed branch/jump formats.
- `out_target`  out  XLEN  `out_pc + out_imm`, modulo 2^XLEN.
- `out_pc`, `out_instr`  out  XLEN / 32  passthrough of the input fields.

## Operation
- **Word classification**
  - `in_instr[1:0]==2'b11`: 32-bit word.
  - Otherwise the word is compressed if `RVC_EN=1`.
  - If `RVC_EN=0`, a compressed word decodes as fmt NONE.
- **32-bit decode** by opcode:
  - I (0000011, 0010011, 1100111, 1110011, 0001111): `{sext, i[31:20]}`.
  - S (0100011): `{sext, i[31:25], i[11:7]}`.
  - B (1100011): `{sext, i[31], i[7], i[30:25], i[11:8], 0}`.
  - U (0110111, 0010111): `{i[31:12], 12'b0}`, sign-extended from bit 31 when XLEN=64.
  - J (1101111): `{sext, i[31], i[19:12], i[20], i[30:21], 0}`.
  - Anything else: NONE, immediate 0.
- **Compressed decode**: only quadrant 01 (`[1:0]=01`) is decoded, keyed on funct3 = `i[15:13]`.
  - 000 C.ADDI and 010 C.LI → CI: `imm[5]=i[12]`, `imm[4:0]=i[6:2]`, sign bit = `i[12]`.
  - 101 C.J, and 001 C.JAL (XLEN=32 only) → CBJ with 12-bit offset:
    - `imm[11]=i[12]`, `imm[4]=i[11]`, `imm[9:8]=i[10:9]`, `imm[10]=i[8]`;
    - `imm[6]=i[7]`, `imm[7]=i[6]`, `imm[3:1]=i[5:3]`, `imm[5]=i[2]`;
    - `imm[0]=0`.
  - 110 C.BEQZ and 111 C.BNEZ → CBJ with 9-bit offset:
    - `imm[8]=i[12]`, `imm[4:3]=i[11:10]`, `imm[7:6]=i[6:5]`, `imm[2:1]=i[4:3]`, `imm[5]=i[2]`;
    - `imm[0]=0`.
  - All other compressed words → NONE, immediate 0.
- **Target computation**
  - `out_target` is always computed. It is meaningful only when `out_pcrel=1`.
  - JALR is I-format with `pcrel=0`.
- **Buffering**: one output register plus one skid entry.
  - Accept condition: `in_valid && in_ready`.
  - `in_ready = !skid_valid && !rst`.
  - An accepted beat goes to the output register if it is empty or draining (`out_ready`). Otherwise it goes to the skid entry.
  - When the output drains and the skid entry is full, the skid entry moves to the output register.
  - Ordering is strictly FIFO; no beat is dropped or duplicated.
- **Flush**
  - Clears `out_valid` and `skid_valid` at the next edge.
  - Has priority over a same-cycle accept (that beat is discarded) and over a same-cycle drain.

## Timing
- **Latency**: a beat accepted at edge N has `out_valid=1` and its data visible after edge N; it is consumable in cycle N+1.
- **Throughput**: one beat per cycle while `out_ready=1`. Decode and the adder are combinational ahead of the registers.
- **Backpressure**
  - With `out_ready=0`, at most 2 beats are held.
  - `in_ready` deasserts in the cycle after the second accept.
  - It reasserts in the cycle after the skid entry moves to the output register.
- **Holding**: while `out_valid && !out_ready`, every output stays stable.
- **Reset**
  - Outputs: `out_valid=0`; `out_imm`, `out_fmt`, `out_pcrel`, `out_target`, `out_pc` and `out_instr` all 0.
  - `skid_valid=0`, and `in_ready=0` while `rst=1`.
  - Reset mid-operation discards both entries.

## Structure
- **Package `rv32_imm_pkg`**:
  - `typedef enum logic [2:0]` with NONE=0, I=1, S=2, B=3, U=4, J=5, CI=6, CBJ=7;
  - opcode localparams;
  - `function automatic imm_decode(instr)` returning `{fmt, imm}` at a given XLEN.
- **Sub-module `rv32_imm_dec`**: combinational decode (32-bit and RVC), instantiated once ahead of the skid/output registers. The stage module owns the handshake, flush and adder.

## Test plan
- XLEN=32: `0xFFF00093` (addi x1,x0,-1) → fmt I, imm `0xFFFFFFFF`, pcrel 0, one cycle later.
- XLEN=32: `0xFE000EE3` (beq offset -4) with pc `0x100` → fmt B, imm `0xFFFFFFFC`, pcrel 1, target `0x000000FC`.
- XLEN=64: `0x800000B7` (lui) → fmt U, imm `0xFFFFFFFF80000000`. With `0x123450B7` → imm `0x12345000`.
- RVC_EN=1: `0x50FD` (c.li x1,-1) → fmt CI, imm all-ones. With RVC_EN=0 the same word → fmt NONE, imm 0.
- Backpressure: `out_ready=0`, 3 beats offered.
  - Required: 2 accepted, `in_ready=0` on the third.
  - Then `out_ready=1`: the beats emerge in order on consecutive cycles, the third is accepted, and nothing is lost or duplicated.
- Flush with both entries full and a beat offered in the same cycle → next cycle `out_valid=0`, `in_ready=1`, and the offered beat never appears.
